// File: rtl/hilo_muldiv_unit.sv
// Purpose : iterative 32x32 radix-2 shift-add multiply/accumulate on the HI/LO pair
//           (MULT, MULTU, MADD, MSUB) plus single-cycle MTHI/MTLO moves.
// Latency : multiply commits 33 edges after the accepting edge; MTHI/MTLO commit at the accepting edge.
// Backpr. : o_busy is high while a multiply is in flight; i_start is ignored until it falls.
// Ports   : i_clk, i_rst_n (async active-low), i_start, i_op[2:0], i_a/i_b[31:0] operands,
//           i_kill flush, o_hi/o_lo architectural registers, o_busy, o_done one-cycle commit pulse.
module hilo_muldiv_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_kill,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [1:0] OP_MADD  = 2'd2;
  localparam logic [1:0] OP_MSUB  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_mov_hi;
  logic        w_mov_lo;
  logic        w_commit;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;   // multiplicand, shifted left one place per RUN cycle
  logic [31:0] r_mplier;  // multiplier, shifted right so bit 0 is always the current bit
  logic [4:0]  r_cnt;
  logic        r_sign;
  logic [1:0]  r_op;      // multiply ops all have op[2]=0, so two bits identify them

  logic        w_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_prod;
  logic [63:0] w_result;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and control decode; Kill overrides both acceptance and commit
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_mov_hi = 1'b0;
    w_mov_lo = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_kill) begin
          if (!i_op[2]) begin
            w_accept = 1'b1;
            w_next   = S_RUN;
          end else if (i_op == OP_MTHI) begin
            w_mov_hi = 1'b1;
          end else if (i_op == OP_MTLO) begin
            w_mov_lo = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (i_kill) begin
          w_next = S_IDLE;
        end else if (r_cnt == 5'd31) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_next   = S_IDLE;
        w_commit = !i_kill;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // 0x80000000 negates to itself, which is the correct magnitude read as unsigned
  assign w_signed = (i_op != OP_MULTU);
  assign w_abs_a  = (w_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
  assign w_abs_b  = (w_signed && i_b[31]) ? (32'd0 - i_b) : i_b;

  assign w_prod = r_sign ? (64'd0 - r_acc) : r_acc;

  always_comb begin
    case (r_op)
      OP_MADD: w_result = {r_hi, r_lo} + w_prod;
      OP_MSUB: w_result = {r_hi, r_lo} - w_prod;
      default: w_result = w_prod;
    endcase
  end

  // Datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_done   <= 1'b0;
      r_acc    <= 64'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_cnt    <= 5'd0;
      r_sign   <= 1'b0;
      r_op     <= 2'd0;
    end else begin
      r_done <= w_commit | w_mov_hi | w_mov_lo;
      if (w_accept) begin
        r_mcand  <= {32'd0, w_abs_a};
        r_mplier <= w_abs_b;
        r_acc    <= 64'd0;
        r_cnt    <= 5'd0;
        r_sign   <= w_signed & (i_a[31] ^ i_b[31]);
        r_op     <= i_op[1:0];
      end
      if (r_state == S_RUN) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 5'd1;
      end
      if (w_commit) begin
        {r_hi, r_lo} <= w_result;
      end
      if (w_mov_hi) begin
        r_hi <= i_a;
      end
      if (w_mov_lo) begin
        r_lo <= i_a;
      end
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_done = r_done;
  assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Purpose : self-checking bench for hilo_muldiv_unit against a cycle-count arithmetic model.
// Latency : model commits a multiply 33 edges after acceptance.
// Backpr. : stimulus waits on o_busy with bounded cycle budgets.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  hilo_muldiv_unit dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .i_kill  (kill),
    .o_hi    (hi),
    .o_lo    (lo),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi, m_lo;
  logic        m_done;
  int          m_cnt;       // edges remaining until a pending multiply commits
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;

  function automatic logic [63:0] mul_result(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y, input logic [63:0] hilo);
    logic signed [63:0] sx, sy;
    logic [63:0] sp, up;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    sp = sx * sy;
    up = {32'd0, x} * {32'd0, y};
    case (o)
      3'd0:    return sp;
      3'd1:    return up;
      3'd2:    return hilo + sp;
      default: return hilo - sp;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_done = 0; m_cnt = 0;
      m_op = 0; m_a = 0; m_b = 0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        if (kill) m_cnt = 0;
        else begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            {m_hi, m_lo} = mul_result(m_op, m_a, m_b, {m_hi, m_lo});
            m_done = 1'b1;
          end
        end
      end else if (start && !kill) begin
        if (op < 3'd4) begin
          m_op = op; m_a = a; m_b = b; m_cnt = 33;
        end else if (op == 3'd4) begin
          m_hi = a; m_done = 1'b1;
        end else if (op == 3'd5) begin
          m_lo = a; m_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_hi",   {32'd0, hi}, {32'd0, m_hi});
      chk("cyc_lo",   {32'd0, lo}, {32'd0, m_lo});
      chk("cyc_busy", {63'd0, busy}, {63'd0, (m_cnt > 0)});
      chk("cyc_done", {63'd0, done}, {63'd0, m_done});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk({name, "_timeout"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #2;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #2;
    start = 1'b0; a = $urandom; b = $urandom;
    wait_idle("issue");
  endtask

  initial begin
    int busy_cyc, done_cyc;
    rst_n = 1'b0; start = 0; op = 0; a = 0; b = 0; kill = 0;
    #23;
    chk("rst_hi",   {32'd0, hi}, 64'd0);
    chk("rst_lo",   {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Test 1: -3 * 7, latency and Done width
    @(posedge clk); #2;
    start = 1'b1; op = 3'd0; a = 32'hFFFFFFFD; b = 32'h7;
    @(posedge clk); #2;
    start = 1'b0; a = 32'h0; b = 32'h0;
    busy_cyc = 0; done_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) done_cyc++;
    end
    chk("t1_busy_cycles", busy_cyc, 33);
    chk("t1_done_cycles", done_cyc, 1);
    chk("t1_hi", {32'd0, hi}, 64'hFFFFFFFF);
    chk("t1_lo", {32'd0, lo}, 64'hFFFFFFEB);

    // Test 2: signed overflow magnitude and unsigned max
    issue(3'd0, 32'h80000000, 32'h80000000);
    chk("t2_hi", {32'd0, hi}, 64'h40000000);
    chk("t2_lo", {32'd0, lo}, 64'h0);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("t2u_hi", {32'd0, hi}, 64'hFFFFFFFE);
    chk("t2u_lo", {32'd0, lo}, 64'h1);

    // Test 3: moves then accumulate
    issue(3'd4, 32'h0, 32'h0);
    issue(3'd5, 32'h5, 32'h0);
    chk("t3_mv_hi", {32'd0, hi}, 64'h0);
    chk("t3_mv_lo", {32'd0, lo}, 64'h5);
    issue(3'd2, 32'h2, 32'h3);
    chk("t3_madd_hi", {32'd0, hi}, 64'h0);
    chk("t3_madd_lo", {32'd0, lo}, 64'hB);
    issue(3'd3, 32'h1, 32'hC);
    chk("t3_msub_hi", {32'd0, hi}, 64'hFFFFFFFF);
    chk("t3_msub_lo", {32'd0, lo}, 64'hFFFFFFFF);

    // Test 4: kill at RUN cycle 10, then a normal op
    @(posedge clk); #2;
    start = 1'b1; op = 3'd0; a = 32'h1234; b = 32'h5678;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 kill = 1'b1;
    @(posedge clk); #2 kill = 1'b0;
    @(negedge clk);
    chk("t4_busy_after_kill", {63'd0, busy}, 64'd0);
    chk("t4_hi_kept", {32'd0, hi}, 64'hFFFFFFFF);
    chk("t4_lo_kept", {32'd0, lo}, 64'hFFFFFFFF);
    issue(3'd0, 32'd6, 32'd7);
    chk("t4_hi", {32'd0, hi}, 64'h0);
    chk("t4_lo", {32'd0, lo}, 64'h2A);

    // Test 5: Start held through Busy with changing operands
    @(posedge clk); #2;
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
    @(posedge clk); #2;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 3));
      @(negedge clk);
      if (!busy) begin start = 1'b0; break; end
      @(posedge clk); #2;
    end
    start = 1'b0;
    chk("t5_hi", {32'd0, hi}, 64'h0);
    chk("t5_lo", {32'd0, lo}, 64'hF);
    wait_idle("t5");

    // Random phase: model covers every op, kills and ignored starts
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 3) != 0);
      op    = 3'($urandom_range(0, 7));
      a     = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      b     = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      kill  = ($urandom_range(0, 40) == 0);
    end
    @(posedge clk); #2;
    start = 1'b0; kill = 1'b0;
    wait_idle("rand");

    // Reset mid-RUN, off the clock edge
    issue(3'd5, 32'hDEADBEEF, 32'h0);
    issue(3'd4, 32'h12345678, 32'h0);
    @(posedge clk); #2;
    start = 1'b1; op = 3'd0; a = 32'h77; b = 32'h99;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_hi",   {32'd0, hi}, 64'd0);
    chk("rst_mid_lo",   {32'd0, lo}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    issue(3'd0, 32'd6, 32'd7);
    chk("post_rst_hi", {32'd0, hi}, 64'h0);
    chk("post_rst_lo", {32'd0, lo}, 64'h2A);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
